// File: rtl/bist_pkg.sv
// Shared definitions for the logic BIST engine: FSM states, default
// generator/compactor taps and the legality check for parameter sets.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } bist_state_e;

    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
    localparam logic [20:0] DEF_MISR_TAPS = 21'h140000;

    // Every chain and PI needs its own LFSR bit, every chain and PO its own MISR bit.
    function automatic bit params_ok(input int n_chain, input int chain_len,
                                     input int n_pi, input int n_po,
                                     input int n_patterns,
                                     input int lfsr_w, input int misr_w);
        return (n_chain >= 1) && (n_chain <= 8) && (chain_len >= 2) &&
               (n_pi >= 1) && (n_po >= 1) && (n_patterns >= 1) &&
               (n_chain + n_pi <= lfsr_w) && (n_chain + n_po <= misr_w);
    endfunction

endpackage

// File: rtl/bist_misr_p.sv
// Multiple-input signature register: Galois-free shift-left MISR that folds
// the response vector into the signature whenever enabled.
module bist_misr_p
    import bist_pkg::*;
#(
    parameter int           W    = 21,
    parameter logic [W-1:0] TAPS = DEF_MISR_TAPS,
    parameter int           N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    input  logic [N_IN-1:0] in_vec,
    output logic [W-1:0]    sig
);

    logic [W-1:0] in_ext;
    logic         fb;

    assign in_ext = W'(in_vec);
    assign fb     = ^(sig & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[W-2:0], fb} ^ in_ext;
        end
    end

endmodule

// File: rtl/bist_engine_p.sv
// Scan-based logic BIST controller: an LFSR feeds the chains and PIs, the CUT
// response is compacted into a MISR and compared against a golden signature.
module bist_engine_p
    import bist_pkg::*;
#(
    parameter int                 N_CHAIN    = 1,
    parameter int                 CHAIN_LEN  = 32,
    parameter int                 N_PI       = 3,
    parameter int                 N_PO       = 2,
    parameter int                 N_PATTERNS = 100,
    parameter int                 LFSR_W     = 16,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS  = DEF_LFSR_TAPS,
    parameter logic [LFSR_W-1:0]  SEED       = 16'h0001,
    parameter int                 MISR_W     = 21,
    parameter logic [MISR_W-1:0]  MISR_TAPS  = DEF_MISR_TAPS,
    parameter logic [MISR_W-1:0]  GOLDEN     = 21'h0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                abort,
    input  logic [N_CHAIN-1:0]  scan_out,
    input  logic [N_PO-1:0]     po,
    output logic                scan_en,
    output logic [N_CHAIN-1:0]  scan_in,
    output logic [N_PI-1:0]     pi_vec,
    output logic                test_mode,
    output logic                running,
    output logic                bist_end,
    output logic                pass_fail,
    output logic [MISR_W-1:0]   signature
);

    if (!params_ok(N_CHAIN, CHAIN_LEN, N_PI, N_PO, N_PATTERNS, LFSR_W, MISR_W)) begin : g_param_err
        $error("bist_engine_p: illegal parameter combination");
    end

    localparam int                PAT_W    = $clog2(N_PATTERNS + 1);
    localparam int                SH_W     = $clog2(CHAIN_LEN);
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [PAT_W-1:0]  LAST_PAT = PAT_W'(N_PATTERNS);
    localparam logic [SH_W-1:0]   LAST_SH  = SH_W'(CHAIN_LEN - 1);

    bist_state_e       state;
    bist_state_e       state_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_step;
    logic [PAT_W-1:0]  pat_cnt;
    logic [PAT_W-1:0]  pat_inc;
    logic [SH_W-1:0]   sh_cnt;
    logic              sh_last;
    logic              abort_hit;
    logic              misr_clear;
    logic              misr_en;

    assign lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign pat_inc   = pat_cnt + PAT_W'(1);
    assign sh_last   = (sh_cnt == LAST_SH);
    assign abort_hit = abort && (state != ST_IDLE);

    assign scan_in = lfsr[N_CHAIN-1:0];
    assign pi_vec  = lfsr[N_CHAIN +: N_PI];

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_INIT;
            ST_INIT:    state_nxt = ST_SHIFT;
            ST_SHIFT:   if (sh_last) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = (pat_inc == LAST_PAT) ? ST_UNLOAD : ST_SHIFT;
            ST_UNLOAD:  if (sh_last) state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_DONE;
            ST_DONE:    if (!start) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            lfsr      <= SEED;
            pat_cnt   <= '0;
            sh_cnt    <= '0;
            scan_en   <= 1'b0;
            test_mode <= 1'b0;
            running   <= 1'b0;
            bist_end  <= 1'b0;
            pass_fail <= 1'b0;
        end else begin
            state     <= state_nxt;
            scan_en   <= (state_nxt == ST_SHIFT) || (state_nxt == ST_UNLOAD);
            test_mode <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            running   <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            bist_end  <= (state_nxt == ST_DONE);
            case (state)
                ST_INIT: begin
                    lfsr      <= SEED_EFF;
                    pat_cnt   <= '0;
                    sh_cnt    <= '0;
                    pass_fail <= 1'b0;
                end
                ST_SHIFT, ST_UNLOAD: begin
                    lfsr   <= lfsr_step;
                    sh_cnt <= sh_last ? '0 : sh_cnt + SH_W'(1);
                end
                ST_CAPTURE: pat_cnt   <= pat_inc;
                ST_COMPARE: pass_fail <= (signature == GOLDEN);
                default: ;
            endcase
            if (abort_hit) pass_fail <= 1'b0;
        end
    end

    // Pattern 0's unload carries whatever the CUT held before the run, so it is not compacted.
    assign misr_clear = (state == ST_INIT);
    assign misr_en    = ((state == ST_SHIFT) && (pat_cnt != '0)) || (state == ST_UNLOAD);

    bist_misr_p #(
        .W    (MISR_W),
        .TAPS (MISR_TAPS),
        .N_IN (N_CHAIN + N_PO)
    ) u_misr (
        .clk    (CLK),
        .rst_n  (RST),
        .clear  (misr_clear),
        .en     (misr_en),
        .in_vec ({po, scan_out}),
        .sig    (signature)
    );

endmodule

// File: tb/tb_bist_engine_p.sv
// Bench for bist_engine_p: small scan CUT model plus a pattern-level
// reference of the whole BIST procedure that supplies the golden signature.
module tb_bist_engine_p;

    localparam int                N_CHAIN    = 1;
    localparam int                CHAIN_LEN  = 8;
    localparam int                N_PI       = 3;
    localparam int                N_PO       = 2;
    localparam int                N_PATTERNS = 4;
    localparam int                LFSR_W     = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED       = 16'h0001;
    localparam int                MISR_W     = 21;
    localparam logic [MISR_W-1:0] MISR_TAPS  = 21'h140000;
    localparam int                RUN_CYCLES = 1 + N_PATTERNS * (CHAIN_LEN + 1) + CHAIN_LEN + 1;

    logic                CLK = 1'b0;
    logic                RST;
    logic                start;
    logic                abort;
    logic [N_CHAIN-1:0]  scan_out;
    logic [N_PO-1:0]     po;
    logic                scan_en;
    logic [N_CHAIN-1:0]  scan_in;
    logic [N_PI-1:0]     pi_vec;
    logic                test_mode;
    logic                running;
    logic                bist_end;
    logic                pass_fail;
    logic [MISR_W-1:0]   signature;

    int                   n_checks = 0;
    int                   n_pass   = 0;
    bit                   stuck    = 1'b0;
    logic [CHAIN_LEN-1:0] cut_chain = '0;

    function automatic logic [N_PO-1:0] cut_po(input logic [CHAIN_LEN-1:0] ch,
                                               input logic [N_PI-1:0] pi);
        logic [CHAIN_LEN-1:0] pi_ext;
        pi_ext = CHAIN_LEN'(pi);
        return {^(ch & pi_ext), ch[0] ^ pi[1]};
    endfunction

    function automatic logic [CHAIN_LEN-1:0] cut_capture(input logic [CHAIN_LEN-1:0] ch,
                                                         input logic [N_PI-1:0] pi);
        return ~ch ^ {ch[0], ch[CHAIN_LEN-1:1]} ^ CHAIN_LEN'(pi);
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                    input logic [MISR_W-1:0] v);
        return {m[MISR_W-2:0], ^(m & MISR_TAPS)} ^ v;
    endfunction

    // Walks the test pattern by pattern: load, capture, and the final unload.
    function automatic logic [MISR_W-1:0] ref_sig(input bit stuck_at);
        logic [LFSR_W-1:0]    g;
        logic [MISR_W-1:0]    m;
        logic [CHAIN_LEN-1:0] ch;
        logic [N_PI-1:0]      pi;
        logic                 so;
        g  = SEED;
        m  = '0;
        ch = '0;
        for (int p = 0; p <= N_PATTERNS; p++) begin
            for (int k = 0; k < CHAIN_LEN; k++) begin
                pi = g[N_CHAIN +: N_PI];
                so = stuck_at ? 1'b1 : ch[CHAIN_LEN-1];
                if (p > 0) m = misr_next(m, MISR_W'({cut_po(ch, pi), so}));
                ch = {ch[CHAIN_LEN-2:0], g[0]};
                g  = lfsr_next(g);
            end
            if (p < N_PATTERNS) ch = cut_capture(ch, g[N_CHAIN +: N_PI]);
        end
        return m;
    endfunction

    localparam logic [MISR_W-1:0] GOLDEN = ref_sig(1'b0);

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (scan_en) cut_chain <= {cut_chain[CHAIN_LEN-2:0], scan_in[0]};
        else if (test_mode) cut_chain <= cut_capture(cut_chain, pi_vec);
    end

    assign scan_out = stuck ? 1'b1 : cut_chain[CHAIN_LEN-1];
    assign po       = cut_po(cut_chain, pi_vec);

    bist_engine_p #(
        .N_CHAIN    (N_CHAIN),
        .CHAIN_LEN  (CHAIN_LEN),
        .N_PI       (N_PI),
        .N_PO       (N_PO),
        .N_PATTERNS (N_PATTERNS),
        .LFSR_W     (LFSR_W),
        .LFSR_TAPS  (LFSR_TAPS),
        .SEED       (SEED),
        .MISR_W     (MISR_W),
        .MISR_TAPS  (MISR_TAPS),
        .GOLDEN     (GOLDEN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .scan_out  (scan_out),
        .po        (po),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .pi_vec    (pi_vec),
        .test_mode (test_mode),
        .running   (running),
        .bist_end  (bist_end),
        .pass_fail (pass_fail),
        .signature (signature)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        @(negedge CLK);
        start = s;
        abort = a;
    endtask

    // Returns on the negedge where the run has been active for 'target' cycles (INIT = 0).
    task automatic wait_run_idx(input int target);
        int idx;
        bit ok;
        idx = -1;
        ok  = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge CLK);
            if (idx < 0) begin
                if (running) idx = 0;
            end else begin
                idx++;
            end
            if (idx == target) ok = 1'b1;
        end
        if (!ok) checkOutput("wait_run_idx_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_to_done(output int lat, output int capt);
        int idx;
        idx  = -1;
        lat  = -1;
        capt = 0;
        for (int c = 0; c < 400 && lat < 0; c++) begin
            @(negedge CLK);
            if (idx < 0) begin
                if (running) idx = 0;
            end else begin
                idx++;
            end
            if (idx == 1) begin
                checkOutput("first_scan_in", scan_in, SEED[N_CHAIN-1:0]);
                checkOutput("first_pi_vec", pi_vec, SEED[N_CHAIN +: N_PI]);
            end
            if (idx >= 1 && idx <= RUN_CYCLES - 2 && !scan_en) capt++;
            if (idx >= 0 && bist_end) lat = idx;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int capt;
        bit saw;
        RST   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        $display("[TB] golden signature %0h", GOLDEN);
        repeat (2) @(negedge CLK);
        checkOutput("rst_scan_en", scan_en, 0);
        checkOutput("rst_test_mode", test_mode, 0);
        checkOutput("rst_running", running, 0);
        checkOutput("rst_bist_end", bist_end, 0);
        checkOutput("rst_pass_fail", pass_fail, 0);
        checkOutput("rst_signature", signature, 0);
        checkOutput("rst_scan_in", scan_in, SEED[N_CHAIN-1:0]);
        RST = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge CLK);

        applyStimulus(1'b1, 1'b0);
        run_to_done(lat, capt);
        checkOutput("latency", lat, RUN_CYCLES);
        checkOutput("capture_cycles", capt, N_PATTERNS);
        checkOutput("pass_sig", signature, GOLDEN);
        checkOutput("pass_flag", pass_fail, 1);

        saw = 1'b0;
        repeat (10 + $urandom_range(0, 10)) begin
            @(negedge CLK);
            if (running || !bist_end) saw = 1'b1;
        end
        checkOutput("no_retrigger", saw, 0);
        checkOutput("done_hold_pass", pass_fail, 1);
        applyStimulus(1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("done_exit_end", bist_end, 0);
        checkOutput("done_exit_running", running, 0);

        applyStimulus(1'b1, 1'b0);
        run_to_done(lat, capt);
        checkOutput("restart_latency", lat, RUN_CYCLES);
        checkOutput("restart_sig", signature, GOLDEN);
        applyStimulus(1'b0, 1'b0);

        stuck = 1'b1;
        applyStimulus(1'b1, 1'b0);
        run_to_done(lat, capt);
        checkOutput("fault_latency", lat, RUN_CYCLES);
        checkOutput("fault_flag", pass_fail, 0);
        checkOutput("fault_sig", signature, ref_sig(1'b1));
        applyStimulus(1'b0, 1'b0);
        stuck = 1'b0;

        // Abort while start is still high during a shift of pattern 2.
        applyStimulus(1'b1, 1'b0);
        wait_run_idx(1 + 2 * (CHAIN_LEN + 1) + int'($urandom_range(0, CHAIN_LEN - 1)));
        abort = 1'b1;
        @(negedge CLK);
        checkOutput("abort_running", running, 0);
        checkOutput("abort_bist_end", bist_end, 0);
        checkOutput("abort_test_mode", test_mode, 0);
        checkOutput("abort_scan_en", scan_en, 0);
        abort = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0);
        run_to_done(lat, capt);
        checkOutput("abort_rerun_sig", signature, GOLDEN);
        checkOutput("abort_rerun_flag", pass_fail, 1);

        abort = 1'b1;
        @(negedge CLK);
        checkOutput("abort_done_flag", pass_fail, 0);
        checkOutput("abort_done_end", bist_end, 0);
        abort = 1'b0;
        start = 1'b0;
        @(negedge CLK);

        // Asynchronous reset in the middle of a random shift cycle.
        applyStimulus(1'b1, 1'b0);
        wait_run_idx(1 + (CHAIN_LEN + 1) * int'($urandom_range(0, N_PATTERNS - 1)) +
                     int'($urandom_range(0, CHAIN_LEN - 1)));
        #2 RST = 1'b0;
        #1;
        checkOutput("async_rst_scan_en", scan_en, 0);
        checkOutput("async_rst_test_mode", test_mode, 0);
        checkOutput("async_rst_running", running, 0);
        checkOutput("async_rst_signature", signature, 0);
        checkOutput("async_rst_scan_in", scan_in, SEED[N_CHAIN-1:0]);
        checkOutput("async_rst_pi_vec", pi_vec, SEED[N_CHAIN +: N_PI]);
        @(negedge CLK);
        start = 1'b0;
        RST   = 1'b1;
        applyStimulus(1'b1, 1'b0);
        run_to_done(lat, capt);
        checkOutput("post_rst_latency", lat, RUN_CYCLES);
        checkOutput("post_rst_sig", signature, GOLDEN);
        checkOutput("post_rst_flag", pass_fail, 1);
        applyStimulus(1'b0, 1'b0);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_engine_p.md
BIST_ENGINE_P -- requirements
Module: bist_engine_p

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
 - N_CHAIN, 1, scan chains driven and compacted (1..8)
 - CHAIN_LEN, 32, flops per chain
 - N_PI, 3, primary inputs driven during test
 - N_PO, 2, primary outputs compacted
 - N_PATTERNS, 100, scan patterns applied
 - LFSR_W, 16, generator width; N_CHAIN+N_PI <= LFSR_W
 - LFSR_TAPS, 16'hB400, generator feedback taps
 - SEED, 16'h0001, generator load value
 - MISR_W, 21, signature width; N_CHAIN+N_PO <= MISR_W
 - MISR_TAPS, 21'h140000, signature feedback taps
 - GOLDEN, 21'h0, expected signature
REQ-002 Ports SHALL be, as name, direction, width, meaning:
 - CLK, in, 1, single clock, rising edge
 - RST, in, 1, asynchronous active-low reset
 - start, in, 1, level request to run BIST
 - abort, in, 1, cancel run
 - scan_out, in, N_CHAIN, chain outputs from CUT
 - po, in, N_PO, CUT primary outputs
 - scan_en, out, 1, CUT scan enable
 - scan_in, out, N_CHAIN, chain inputs to CUT
 - pi_vec, out, N_PI, test values for CUT primary inputs
 - test_mode, out, 1, input-mux select: 1 = pi_vec drives CUT
 - running, out, 1, high in any state except IDLE and DONE
 - bist_end, out, 1, high in DONE
 - pass_fail, out, 1, 1 = signature equals GOLDEN; valid when bist_end=1
 - signature, out, MISR_W, current MISR contents

Function
REQ-003 The FSM SHALL have states IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE and DONE.
REQ-004 IDLE SHALL go to INIT when start=1.
REQ-005 INIT SHALL last 1 cycle: load LFSR with SEED (with 1 if SEED==0), clear MISR, clear both counters, then go to SHIFT.
REQ-006 SHIFT SHALL last exactly CHAIN_LEN cycles with scan_en=1, advancing the LFSR every cycle.
REQ-007 CAPTURE SHALL last 1 cycle with scan_en=0 and the LFSR held, then increment the pattern counter.
REQ-008 After CAPTURE the FSM SHALL go to UNLOAD if the pattern counter equals N_PATTERNS, otherwise to SHIFT.
REQ-009 UNLOAD SHALL last CHAIN_LEN cycles with scan_en=1 and the LFSR advancing.
REQ-010 COMPARE SHALL last 1 cycle and register pass_fail = (MISR == GOLDEN).
REQ-011 DONE SHALL hold bist_end=1 and pass_fail, and SHALL return to IDLE only when start=0; start held high SHALL NOT retrigger a run.
REQ-012 LFSR update SHALL be: shift left by one, with bit0 = XOR of state bits selected by LFSR_TAPS.
REQ-013 scan_in[c] SHALL equal lfsr[c] and pi_vec[k] SHALL equal lfsr[N_CHAIN+k], both combinational from the LFSR register.
REQ-014 MISR update SHALL be: next = {misr[MISR_W-2:0], fb} XOR in_vec, where fb = XOR of misr bits selected by MISR_TAPS and in_vec = {po, scan_out} zero-extended to MISR_W (scan_out in the LSBs).
REQ-015 The MISR SHALL update only in SHIFT and UNLOAD cycles, excluding every SHIFT cycle of pattern 0, whose unload data is stale.
REQ-016 test_mode SHALL be 1 in all states from INIT through COMPARE, and 0 otherwise.
REQ-017 abort=1 in any state except IDLE SHALL force IDLE on the next edge and clear pass_fail and bist_end; abort has priority over start in the same cycle.
REQ-018 The cycle count from the first cycle of INIT to the first cycle of DONE SHALL be 1 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1.

Reset
REQ-019 RST=0 SHALL asynchronously force IDLE with LFSR=SEED, MISR=0, counters=0, scan_en=0, test_mode=0, running=0, bist_end=0 and pass_fail=0.
REQ-020 Reset asserted mid-run SHALL abandon the run, and no residual state SHALL affect the next run.

Structure
REQ-021 A shared package bist_pkg SHALL hold the state enum, default tap constants, and the elaboration checks on parameter width limits.
REQ-022 The MISR SHALL be a sub-module bist_misr_p, parametrised by width, taps and input count, with an enable input; the LFSR, counters and FSM stay in bist_engine_p.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
 - Reset: RST=0 mid-SHIFT -> all outputs at reset values immediately, with no clock edge needed.
 - Latency: N_PATTERNS=4, CHAIN_LEN=8, start=1 -> bist_end rises exactly 46 cycles after INIT entry, scan_en=0 in exactly 4 cycles.
 - Pass: fault-free CUT model with GOLDEN from the reference model -> pass_fail=1, signature==GOLDEN.
 - Fault: scan_out[0] stuck-at-1 with the same GOLDEN -> pass_fail=0.
 - Abort: abort=1 at pattern 2 -> IDLE next cycle, running=0, bist_end=0, then a rerun gives the identical signature.
 - Start handling: start held high through DONE -> no rerun; drop then re-raise start -> new run with the same signature.
